// File: rtl/imc_pkg.sv
// Shared types and constants for the IMC MAC sequencer: FSM state encoding,
// ext_state codes and default parameter values.
package imc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRECH = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRIVE = 3'd3,
    ST_SENSE = 3'd4,
    ST_ACCUM = 3'd5,
    ST_OUT   = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam logic [1:0] EXT_IDLE    = 2'd0;
  localparam logic [1:0] EXT_COMPUTE = 2'd1;
  localparam logic [1:0] EXT_OUTPUT  = 2'd2;
  localparam logic [1:0] EXT_DONE    = 2'd3;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_SA_W      = 4;
  localparam int DEF_ACC_W     = 12;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_SETTLE_W  = 4;
  localparam int DEF_PRECH_CYC = 2;

  function automatic logic [1:0] ext_of(input state_t s);
    case (s)
      ST_IDLE: ext_of = EXT_IDLE;
      ST_OUT:  ext_of = EXT_OUTPUT;
      ST_DONE: ext_of = EXT_DONE;
      default: ext_of = EXT_COMPUTE;
    endcase
  endfunction

endpackage

// File: rtl/imc_acc_lane.sv
// One sense-amp lane: capture register plus accumulator.
// IMC_SAT_EN selects saturating accumulation with overflow flag; otherwise wraps.
module imc_acc_lane #(
  parameter int SA_W  = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             cap_en,
  input  logic             acc_en,
  input  logic [SA_W-1:0]  sa,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [SA_W-1:0] cap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cap <= '0;
    else if (clr)    cap <= '0;
    else if (cap_en) cap <= sa;
  end

`ifdef IMC_SAT_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {{(ACC_W+1-SA_W){1'b0}}, cap};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (acc_en) begin
      if (sum[ACC_W]) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    acc <= '0;
    else if (clr)    acc <= '0;
    else if (acc_en) acc <= acc + ACC_W'(cap);
  end

  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/imc_mac_sequencer.sv
// Job sequencer for the SRAM in-memory-compute array: precharge, fetch, drive,
// sense and accumulate per vector. Optional saturation via IMC_SAT_EN.
//
// state | meaning
// IDLE  | waiting for start
// PRECH | bitline clamp/precharge, PRECH_CYC cycles
// FETCH | waiting for an input-buffer word
// DRIVE | wordline driven, cfg_settle+1 cycles
// SENSE | wordline + sense-amp strobe, results captured
// ACCUM | lanes accumulate, vector counter advances
// OUT   | result presented until ob_ready
// DONE  | one-cycle completion pulse
module imc_mac_sequencer
  import imc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SA_W      = DEF_SA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int SETTLE_W  = DEF_SETTLE_W,
  parameter int PRECH_CYC = DEF_PRECH_CYC
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic [SETTLE_W-1:0]     cfg_settle,
  input  logic [DATA_W-1:0]       ib_data,
  input  logic                    ib_valid,
  output logic                    ib_ready,
  output logic                    en_vclp,
  output logic                    wl_en,
  output logic [DATA_W-1:0]       wl_data,
  output logic                    sa_en,
  input  logic [NUM_CH*SA_W-1:0]  sa_data,
  output logic [NUM_CH*ACC_W-1:0] ob_data,
  output logic                    ob_valid,
  input  logic                    ob_ready,
  output logic                    mac_starting,
  output logic                    done,
  output logic                    ovf,
  output logic [1:0]              ext_state,
  output logic [2:0]              int_state
);

  localparam int PW    = $clog2(PRECH_CYC + 1);
  localparam int TMR_W = (SETTLE_W > PW) ? SETTLE_W : PW;

  generate
    if (ACC_W < SA_W) begin : g_bad_acc_w
      $error("imc_mac_sequencer: ACC_W must be >= SA_W");
    end
    if (PRECH_CYC < 1) begin : g_bad_prech
      $error("imc_mac_sequencer: PRECH_CYC must be >= 1");
    end
  endgenerate

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    tmr;
  logic [LEN_W-1:0]    cnt, len_q;
  logic [LEN_W-1:0]    cnt_inc;
  logic [SETTLE_W-1:0] settle_q;
  logic                clr, cap_en, acc_en;
  logic [NUM_CH-1:0]   lane_ovf;

  assign cnt_inc = cnt + 1'b1;
  assign clr     = (state == ST_IDLE) && start;
  assign cap_en  = (state == ST_SENSE) && !abort;
  assign acc_en  = (state == ST_ACCUM) && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (cfg_len == '0) ? ST_OUT : ST_PRECH;
      ST_PRECH: if (tmr == '0) state_nxt = ST_FETCH;
      ST_FETCH: if (ib_valid) state_nxt = ST_DRIVE;
      ST_DRIVE: if (tmr == '0) state_nxt = ST_SENSE;
      ST_SENSE: state_nxt = ST_ACCUM;
      ST_ACCUM: state_nxt = (cnt_inc == len_q) ? ST_OUT : ST_PRECH;
      ST_OUT:   if (ob_ready) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      cnt          <= '0;
      len_q        <= '0;
      settle_q     <= '0;
      wl_data      <= '0;
      mac_starting <= 1'b0;
    end else begin
      state        <= state_nxt;
      mac_starting <= clr;
      if (clr) begin
        len_q    <= cfg_len;
        settle_q <= cfg_settle;
        cnt      <= '0;
      end else if (acc_en) begin
        cnt <= cnt_inc;
      end
      if (state != ST_PRECH && state_nxt == ST_PRECH) tmr <= TMR_W'(PRECH_CYC - 1);
      else if (state != ST_DRIVE && state_nxt == ST_DRIVE) tmr <= TMR_W'(settle_q);
      else if (tmr != '0) tmr <= tmr - 1'b1;
      // a handshake that coincides with abort is accepted but dropped
      if (state == ST_FETCH && ib_valid && !abort) wl_data <= ib_data;
    end
  end

  assign en_vclp   = (state == ST_PRECH);
  assign ib_ready  = (state == ST_FETCH);
  assign wl_en     = (state == ST_DRIVE) || (state == ST_SENSE);
  assign sa_en     = (state == ST_SENSE);
  assign ob_valid  = (state == ST_OUT);
  assign done      = (state == ST_DONE);
  assign ext_state = ext_of(state);
  assign int_state = state;
  assign ovf       = |lane_ovf;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      imc_acc_lane #(
        .SA_W  (SA_W),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .cap_en  (cap_en),
        .acc_en  (acc_en),
        .sa      (sa_data[i*SA_W +: SA_W]),
        .acc     (ob_data[i*ACC_W +: ACC_W]),
        .ovf     (lane_ovf[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_imc_mac_sequencer.sv
// Directed bench for imc_mac_sequencer (NUM_CH=4, SA_W=4, ACC_W=6, PRECH_CYC=2);
// expectations follow IMC_SAT_EN when the bench is built with it.
module tb_imc_mac_sequencer;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int SA_W   = 4;
  localparam int ACC_W  = 6;

  logic                    clk, reset_n, start, abort, ib_valid, ob_ready;
  logic [7:0]              cfg_len;
  logic [3:0]              cfg_settle;
  logic [DATA_W-1:0]       ib_data, wl_data;
  logic [NUM_CH*SA_W-1:0]  sa_data;
  logic [NUM_CH*ACC_W-1:0] ob_data;
  logic                    ib_ready, en_vclp, wl_en, sa_en, ob_valid;
  logic                    mac_starting, done, ovf;
  logic [1:0]              ext_state;
  logic [2:0]              int_state;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_done  = 0;

  imc_mac_sequencer #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SA_W(SA_W), .ACC_W(ACC_W),
    .LEN_W(8), .SETTLE_W(4), .PRECH_CYC(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_settle(cfg_settle),
    .ib_data(ib_data), .ib_valid(ib_valid), .ib_ready(ib_ready),
    .en_vclp(en_vclp), .wl_en(wl_en), .wl_data(wl_data), .sa_en(sa_en),
    .sa_data(sa_data), .ob_data(ob_data), .ob_valid(ob_valid), .ob_ready(ob_ready),
    .mac_starting(mac_starting), .done(done), .ovf(ovf),
    .ext_state(ext_state), .int_state(int_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mac_starting) n_start++;
    if (done) n_done++;
  end

  typedef struct {
    string      nm;
    logic [7:0] len;
    logic [3:0] settle;
    logic [15:0] sa;
    logic [23:0] exp_ob;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s);
    for (int i = 0; i < 200 && int_state != s; i++) @(negedge clk);
    check(nm, 64'(int_state), 64'(s));
  endtask

  task automatic run_job(input string nm, input logic [7:0] len, input logic [3:0] settle,
                         input logic [15:0] sa, input logic [23:0] exp_ob, input logic exp_ovf);
    int cyc, vclp, wl, sn, s0, d0;
    logic [31:0] pat;
    s0 = n_start;
    d0 = n_done;
    pat = 32'hC0DE_0000 | 32'(len);
    cfg_len = len; cfg_settle = settle; sa_data = sa; ib_data = pat; ib_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; vclp = 0; wl = 0; sn = 0;
    while (!ob_valid && cyc < 2000) begin
      cyc++;
      if (en_vclp) vclp++;
      if (wl_en) wl++;
      if (sa_en) sn++;
      @(negedge clk);
    end
    check({nm, "_cycles"}, 64'(cyc), 64'(int'(len) * (int'(settle) + 6)));
    check({nm, "_vclp"}, 64'(vclp), 64'(2 * int'(len)));
    check({nm, "_wl_en"}, 64'(wl), 64'(int'(len) * (int'(settle) + 2)));
    check({nm, "_sa_en"}, 64'(sn), 64'(len));
    check({nm, "_ob_data"}, 64'(ob_data), 64'(exp_ob));
    check({nm, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    check({nm, "_wl_data"}, 64'(wl_data), 64'(pat));
    check({nm, "_ext_out"}, 64'(ext_state), 64'd2);
    ob_ready = 1'b1;
    @(negedge clk);
    ob_ready = 1'b0;
    check({nm, "_done"}, {61'd0, done, ext_state}, {61'd0, 1'b1, 2'd3});
    @(negedge clk);
    check({nm, "_idle"}, {60'd0, done, int_state}, 64'd0);
    @(negedge clk);
    check({nm, "_pulses"}, {32'(n_start - s0), 32'(n_done - d0)}, {32'd1, 32'd1});
  endtask

  function automatic logic [63:0] ctl_bundle();
    return 64'({en_vclp, wl_en, sa_en, ib_ready, ob_valid, mac_starting, done, ovf,
                ext_state, int_state});
  endfunction

  initial begin
    int s0, d0, bad_cyc;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ib_valid = 1'b0; ob_ready = 1'b0;
    cfg_len = '0; cfg_settle = '0; ib_data = '0; sa_data = '0;

    vecs[0] = '{"t1", 8'd3, 4'd1, {4'd7, 4'd0, 4'd1, 4'd15}, {6'd21, 6'd0, 6'd3, 6'd45}, 1'b0};
`ifdef IMC_SAT_EN
    vecs[1] = '{"t2_sat", 8'd5, 4'd0, {4'd0, 4'd0, 4'd0, 4'd15}, {6'd0, 6'd0, 6'd0, 6'd63}, 1'b1};
`else
    vecs[1] = '{"t2_wrap", 8'd5, 4'd0, {4'd0, 4'd0, 4'd0, 4'd15}, {6'd0, 6'd0, 6'd0, 6'd11}, 1'b0};
`endif
    vecs[2] = '{"mix", 8'd2, 4'd3, {4'd1, 4'd2, 4'd3, 4'd4}, {6'd2, 6'd4, 6'd6, 6'd8}, 1'b0};
    vecs[3] = '{"settle15", 8'd1, 4'd15, {4'd15, 4'd15, 4'd15, 4'd15}, {6'd15, 6'd15, 6'd15, 6'd15}, 1'b0};
    vecs[4] = '{"edge60", 8'd4, 4'd0, {4'd15, 4'd15, 4'd15, 4'd15}, {6'd60, 6'd60, 6'd60, 6'd60}, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_ctl", ctl_bundle(), 64'd0);
    check("reset_data", 64'({wl_data, ob_data}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_job(vecs[i].nm, vecs[i].len, vecs[i].settle, vecs[i].sa, vecs[i].exp_ob, vecs[i].exp_ovf);

    // ib stall in FETCH, then ob_ready held off in OUT
    ib_valid = 1'b0; cfg_len = 8'd1; cfg_settle = 4'd0; sa_data = {12'd0, 4'd5};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state("t3_reach_fetch", 3'd2);
    bad_cyc = 0;
    repeat (10) begin
      @(negedge clk);
      if (int_state != 3'd2 || wl_en) bad_cyc++;
    end
    check("t3_stall_hold", 64'(bad_cyc), 64'd0);
    ib_valid = 1'b1;
    wait_state("t3_reach_out", 3'd6);
    check("t3_result", 64'(ob_data), 64'h5);
    bad_cyc = 0;
    repeat (5) begin
      @(negedge clk);
      if (!ob_valid || ob_data != 24'h5 || done) bad_cyc++;
    end
    check("t4_out_hold", 64'(bad_cyc), 64'd0);
    ob_ready = 1'b1;
    @(negedge clk);
    ob_ready = 1'b0;
    check("t4_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t4_idle", 64'(int_state), 64'd0);

    // abort in DRIVE
    cfg_len = 8'd2; cfg_settle = 4'd2; sa_data = {12'd0, 4'd3};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state("t5_reach_drive", 3'd3);
    abort = 1'b1;
    d0 = n_done;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_idle", ctl_bundle() & 64'h7FF, 64'd0);
    repeat (10) @(negedge clk);
    check("t5_no_done", 64'(n_done - d0), 64'd0);
    run_job("t5_fresh", 8'd1, 4'd0, {4'd0, 4'd0, 4'd2, 4'd9}, {6'd0, 6'd0, 6'd2, 6'd9}, 1'b0);

    // zero-length job, start ignored while busy
    s0 = n_start;
    cfg_len = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_len0_out", {32'(int_state), 32'(ob_valid)}, {32'd6, 32'd1});
    check("t6_len0_data", 64'(ob_data), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_start_ignored", 64'(int_state), 64'd6);
    ob_ready = 1'b1;
    @(negedge clk);
    ob_ready = 1'b0;
    check("t6_len0_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t6_len0_pulses", 64'(n_start - s0), 64'd1);

    // reset in the middle of a job
    s0 = n_start;
    cfg_len = 8'd3; cfg_settle = 4'd1; sa_data = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_busy_start", 64'(n_start - s0), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_ctl", ctl_bundle(), 64'd0);
    check("t6_rst_data", 64'({wl_data, ob_data}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
